// File: rtl/ruta_datos_multdiv.sv
// Datapath slave of the microprogrammed multiplier/divider: executes one register
// transfer per clock from the control word and exposes the branch flags.
module ruta_datos_multdiv #(
  parameter int ANCHO = 16
) (
  input  logic                 reloj,
  input  logic                 reset,
  input  logic [17:0]          estado,
  input  logic [ANCHO-1:0]     operando1,
  input  logic [ANCHO-1:0]     operando2,
  output logic [2*ANCHO-1:0]   resultado,
  output logic                 listo,
  output logic                 neg1,
  output logic                 neg2,
  output logic                 AEScero,
  output logic                 A0EScero,
  output logic                 CNOcero,
  output logic                 neg1IGUALneg2,
  output logic                 contNOquince,
  output logic                 neg_reg_C_MSB
);
  localparam int CW = $clog2(ANCHO);

  typedef struct packed {
    logic [5:0] rsvd;
    logic       fin;
    logic       negar_ca;
    logic       negar_c;
    logic       negar_a;
    logic       cont_clr;
    logic       cont_inc;
    logic       poner_q;
    logic       desp_izq;
    logic       desp_der;
    logic       restar;
    logic       sumar;
    logic       cargar;
  } ctrl_t;

  ctrl_t ctl;
  assign ctl = ctrl_t'(estado);

  logic [ANCHO-1:0]   a_q, a_d, b_q, b_d;
  logic [ANCHO:0]     c_q, c_d;
  logic [CW-1:0]      cont_q, cont_d;
  logic               neg1_q, neg1_d, neg2_q, neg2_d, listo_q, listo_d;

  logic [ANCHO-1:0]   mag1, mag2, a_neg, c_neg;
  logic [ANCHO:0]     c_sum, c_sub;
  logic [2*ANCHO-1:0] ca_neg;
  logic               unused_rsvd;

  assign unused_rsvd = ^ctl.rsvd;

  // |-2^(ANCHO-1)| wraps to 2^(ANCHO-1), which is exactly the unsigned magnitude wanted
  assign mag1   = operando1[ANCHO-1] ? -operando1 : operando1;
  assign mag2   = operando2[ANCHO-1] ? -operando2 : operando2;
  assign c_sum  = c_q + {1'b0, b_q};
  assign c_sub  = c_q - {1'b0, b_q};
  assign a_neg  = -a_q;
  assign c_neg  = -c_q[ANCHO-1:0];
  assign ca_neg = -{c_q[ANCHO-1:0], a_q};

  always_comb begin
    c_d = c_q;
    if (ctl.cargar)        c_d = '0;
    else if (ctl.sumar)    c_d = c_sum;
    else if (ctl.restar)   c_d = c_sub;
    else if (ctl.desp_der) c_d = {1'b0, c_q[ANCHO:1]};
    else if (ctl.desp_izq) c_d = {c_q[ANCHO-1:0], a_q[ANCHO-1]};
    else if (ctl.negar_ca) c_d = {1'b0, ca_neg[2*ANCHO-1:ANCHO]};
    else if (ctl.negar_c)  c_d = {1'b0, c_neg};

    a_d = a_q;
    if (ctl.cargar)        a_d = mag1;
    else if (ctl.desp_der) a_d = {c_q[0], a_q[ANCHO-1:1]};
    else if (ctl.desp_izq) a_d = {a_q[ANCHO-2:0], 1'b0};
    else if (ctl.negar_ca) a_d = ca_neg[ANCHO-1:0];
    else if (ctl.negar_a)  a_d = a_neg;
    else if (ctl.poner_q)  a_d = {a_q[ANCHO-1:1], 1'b1};

    b_d    = ctl.cargar ? mag2 : b_q;
    neg1_d = ctl.cargar ? operando1[ANCHO-1] : neg1_q;
    neg2_d = ctl.cargar ? operando2[ANCHO-1] : neg2_q;

    cont_d = cont_q;
    if (ctl.cont_clr)      cont_d = '0;
    else if (ctl.cont_inc) cont_d = cont_q + CW'(1);

    listo_d = listo_q;
    if (ctl.cargar)        listo_d = 1'b0;
    else if (ctl.fin)      listo_d = 1'b1;
  end

  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cont_q  <= '0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      listo_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cont_q  <= cont_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      listo_q <= listo_d;
    end
  end

  // Flags are combinational so the falling-edge controller sees this cycle's update
  assign resultado     = {c_q[ANCHO-1:0], a_q};
  assign listo         = listo_q;
  assign neg1          = neg1_q;
  assign neg2          = neg2_q;
  assign AEScero       = (a_q == '0);
  assign A0EScero      = ~a_q[0];
  assign CNOcero       = (c_q != '0);
  assign neg1IGUALneg2 = (neg1_q == neg2_q);
  assign contNOquince  = (cont_q != CW'(ANCHO-1));
  assign neg_reg_C_MSB = ~c_q[ANCHO];

endmodule

// File: tb/tb_ruta_datos_multdiv.sv
// Directed bench for ruta_datos_multdiv: drives microcode sequences and checks
// results and flags against hand-computed values.
module tb_ruta_datos_multdiv;
  logic        reloj, reset;
  logic [17:0] estado;
  logic [15:0] operando1, operando2;
  logic [31:0] resultado;
  logic        listo, neg1, neg2, AEScero, A0EScero, CNOcero;
  logic        neg1IGUALneg2, contNOquince, neg_reg_C_MSB;

  localparam logic [17:0] CARGAR   = 18'h00001;
  localparam logic [17:0] SUMAR    = 18'h00002;
  localparam logic [17:0] RESTAR   = 18'h00004;
  localparam logic [17:0] DESP_DER = 18'h00008;
  localparam logic [17:0] DESP_IZQ = 18'h00010;
  localparam logic [17:0] PONER_Q  = 18'h00020;
  localparam logic [17:0] CONT_INC = 18'h00040;
  localparam logic [17:0] CONT_CLR = 18'h00080;
  localparam logic [17:0] NEGAR_A  = 18'h00100;
  localparam logic [17:0] NEGAR_C  = 18'h00200;
  localparam logic [17:0] NEGAR_CA = 18'h00400;
  localparam logic [17:0] FIN      = 18'h00800;

  int errors = 0;
  int checks = 0;

  ruta_datos_multdiv #(.ANCHO(16)) dut (
    .reloj(reloj), .reset(reset), .estado(estado),
    .operando1(operando1), .operando2(operando2),
    .resultado(resultado), .listo(listo), .neg1(neg1), .neg2(neg2),
    .AEScero(AEScero), .A0EScero(A0EScero), .CNOcero(CNOcero),
    .neg1IGUALneg2(neg1IGUALneg2), .contNOquince(contNOquince),
    .neg_reg_C_MSB(neg_reg_C_MSB)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {23'd0, listo, neg1, neg2, AEScero, A0EScero, CNOcero,
            neg1IGUALneg2, contNOquince, neg_reg_C_MSB};
  endfunction

  // One control word for one rising edge; sampling happens 1 time unit after it
  task automatic apply(input logic [17:0] cw);
    estado = cw;
    @(posedge reloj);
    #1;
    estado = '0;
  endtask

  task automatic load(input logic [15:0] o1, input logic [15:0] o2);
    operando1 = o1;
    operando2 = o2;
    apply(CARGAR | CONT_CLR);
  endtask

  task automatic mult_iter();
    if (!A0EScero) apply(SUMAR);
    apply(DESP_DER | CONT_INC);
  endtask

  task automatic multiply();
    for (int i = 0; i < 16; i++) mult_iter();
    if (!neg1IGUALneg2) apply(NEGAR_CA);
    apply(FIN);
  endtask

  task automatic divide();
    for (int i = 0; i < 16; i++) begin
      apply(DESP_IZQ);
      apply(RESTAR);
      if (!neg_reg_C_MSB) apply(SUMAR | CONT_INC);
      else                apply(PONER_Q | CONT_INC);
    end
    if (!neg1IGUALneg2) apply(NEGAR_A);
    if (neg1) apply(NEGAR_C);
    apply(FIN);
  endtask

  // Reaches C=0x10001, A=0x8001
  task automatic build_edge();
    operando1 = 16'h4000;
    operando2 = 16'h8000;
    apply(CARGAR);
    apply(NEGAR_A | SUMAR);
    apply(DESP_IZQ);
    apply(PONER_Q);
  endtask

  initial begin
    reset = 1'b0;
    estado = '0;
    operando1 = '0;
    operando2 = '0;
    #12;
    chk("reset_res", resultado, 32'h0);
    chk("reset_flags", flags(), 32'h037);
    @(negedge reloj);
    reset = 1'b1;

    // 3 x -5
    load(16'd3, 16'hFFFB);
    chk("mul1_eq", {31'd0, neg1IGUALneg2}, 32'd0);
    chk("mul1_neg2", {31'd0, neg2}, 32'd1);
    multiply();
    chk("mul1_res", resultado, 32'hFFFFFFF1);
    chk("mul1_listo", {31'd0, listo}, 32'd1);

    // 100 / 7
    load(16'd100, 16'd7);
    chk("cargar_listo", {31'd0, listo}, 32'd0);
    divide();
    chk("div1_res", resultado, 32'h0002000E);

    // -100 / 7
    load(16'hFF9C, 16'd7);
    divide();
    chk("div2_res", resultado, 32'hFFFEFFF2);

    // -32768 x -32768
    load(16'h8000, 16'h8000);
    multiply();
    chk("mul2_res", resultado, 32'h40000000);

    // 5 / 0
    load(16'd5, 16'd0);
    divide();
    chk("div0_res", resultado, 32'h0005FFFF);

    // Priority and counter
    apply(CONT_CLR);
    operando1 = 16'd0;
    operando2 = 16'd5;
    apply(CARGAR | SUMAR | CONT_INC);
    chk("pri_res", resultado, 32'h0);
    chk("pri_cno", {31'd0, CNOcero}, 32'd0);
    chk("pri_listo", {31'd0, listo}, 32'd0);
    for (int i = 0; i < 13; i++) apply(CONT_INC);
    chk("cnt14", {31'd0, contNOquince}, 32'd1);
    apply(CONT_INC);
    chk("cnt15", {31'd0, contNOquince}, 32'd0);
    apply(CONT_INC);
    chk("cnt_wrap", {31'd0, contNOquince}, 32'd1);
    for (int i = 0; i < 14; i++) apply(CONT_INC);
    apply(CONT_CLR | CONT_INC);
    for (int i = 0; i < 15; i++) apply(CONT_INC);
    chk("clr_pri", {31'd0, contNOquince}, 32'd0);

    // Async reset mid-multiply, between edges
    load(16'd7, 16'd6);
    for (int i = 0; i < 5; i++) mult_iter();
    #3;
    reset = 1'b0;
    #1;
    chk("arst_res", resultado, 32'h0);
    chk("arst_flags", flags(), 32'h037);
    @(negedge reloj);
    reset = 1'b1;
    load(16'd7, 16'd6);
    multiply();
    chk("post_rst_res", resultado, 32'h0000002A);
    chk("post_rst_listo", {31'd0, listo}, 32'd1);

    // Shift edges
    build_edge();
    chk("edge_start", resultado, 32'h00018001);
    chk("edge_start_msb", {31'd0, neg_reg_C_MSB}, 32'd0);
    chk("edge_start_a0", {31'd0, A0EScero}, 32'd0);
    apply(DESP_DER);
    chk("dder_res", resultado, 32'h8000C000);
    chk("dder_a0", {31'd0, A0EScero}, 32'd1);
    chk("dder_msb", {31'd0, neg_reg_C_MSB}, 32'd1);
    build_edge();
    apply(DESP_IZQ);
    chk("dizq_res", resultado, 32'h00030002);
    chk("dizq_a0", {31'd0, A0EScero}, 32'd1);
    chk("dizq_msb", {31'd0, neg_reg_C_MSB}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ruta_datos_multdiv.md
Name: ruta_datos_multdiv

Overview:
- Datapath slave of the microprogrammed multiplier/divider controller.
- Consumes the controller's 18-bit control word `estado` and executes one register-transfer per clock.
- Produces the condition flags the controller branches on.
- Performs 16x16 signed shift-add multiplication and 16/16 signed restoring division in sign-magnitude form, with a final two's-complement fix-up.

Parameters:
ANCHO, 16, operand width; registers A and B are ANCHO bits, C is ANCHO+1 bits, cont is log2(ANCHO) bits. All values below assume 16.

Ports:
reloj  input  1  clock; all datapath registers update on the rising edge (the controller updates on the falling edge).
reset  input  1  asynchronous active-low reset.
estado  input  18  control word from the controller (fields below).
operando1  input  16  signed multiplicand / dividend.
operando2  input  16  signed multiplier / divisor.
resultado  output  32  {C[15:0],A}: product, or {remainder, quotient}.
listo  output  1  result valid flag (registered).
neg1  output  1  captured sign of operando1.
neg2  output  1  captured sign of operando2.
AEScero  output  1  A == 0.
A0EScero  output  1  A[0] == 0.
CNOcero  output  1  C != 0.
neg1IGUALneg2  output  1  neg1 == neg2.
contNOquince  output  1  cont != 15.
neg_reg_C_MSB  output  1  ~C[16].

Behaviour:
- Reset (reset=0, asynchronous): A, B, C, cont, neg1, neg2 and listo all 0.
  - Resulting flags: AEScero=1, A0EScero=1, CNOcero=0, neg1IGUALneg2=1, contNOquince=1, neg_reg_C_MSB=1, resultado=0.
  - Reset asserted mid-operation aborts the operation immediately, with no completion.
- Control word fields. An asserted bit acts at the next rising edge; all-zero means every register holds.
  - [0] cargar: A<=|operando1|, B<=|operando2|, C<=0, neg1<=operando1[15], neg2<=operando2[15], listo<=0.
  - [1] sumar: C<=C+B.
  - [2] restar: C<=C-B (17-bit two's complement).
  - [3] desp_der: C<={1'b0,C[16:1]}, A<={C[0],A[15:1]}.
  - [4] desp_izq: C<={C[15:0],A[15]}, A<={A[14:0],1'b0}.
  - [5] poner_q: A[0]<=1.
  - [6] cont_inc: cont<=cont+1; wraps 15->0.
  - [7] cont_clr: cont<=0; has priority over cont_inc.
  - [8] negar_A: A<=-A.
  - [9] negar_C: C[15:0]<=-C[15:0]; C[16]<=0.
  - [10] negar_CA: {C[15:0],A}<=-{C[15:0],A}; C[16]<=0.
  - [11] fin: listo<=1.
  - [17:12] reserved, ignored.
- Register priority when several fields hit the same register (highest wins, lower ones dropped):
  - C: cargar > sumar > restar > desp_der > desp_izq > negar_CA > negar_C.
  - A: cargar > desp_der > desp_izq > negar_CA > negar_A > poner_q.
  - Fields targeting different registers act concurrently; e.g. sumar with cont_inc changes both C and cont.
- Magnitudes are unsigned 16-bit; |-32768| = 0x8000. Arithmetic is unsigned and C[16] is the carry/sign bit.
- Divide invariant: C < B <= 0x8000 before each desp_izq, so C[16] after restar is a valid borrow.
- Division by zero gets no special handling: quotient 0xFFFF, remainder = |dividend| before sign fix-up.
- Flags are purely combinational from registers; they change in the same cycle as a register update and are stable at the controller's falling edge.
- Multiply microcode per bit: if !A0EScero then sumar; then desp_der and cont_inc. Repeat while contNOquince, 16 iterations total. If !neg1IGUALneg2 then negar_CA.
- Divide microcode per bit: desp_izq; restar; if C[16] then sumar else poner_q; cont_inc. Fix-up: if !neg1IGUALneg2 then negar_A; if neg1 then negar_C.
- listo stays 1 until the next cargar or reset.

Test Plan:
- Multiply 3 x -5: cargar(operando1=3, operando2=0xFFFB) then the multiply microcode sequence and fin -> resultado=0xFFFFFFF1, listo=1, neg1IGUALneg2=0 after cargar.
- Divide 100 / 7: cargar(100,7) then 16-iteration divide sequence -> A=14, C[15:0]=2, resultado=0x0002000E; divide -100/7 -> A=0xFFF2, C[15:0]=0xFFFE.
- Extremes: -32768 x -32768 -> resultado=0x40000000; 5/0 -> A=0xFFFF, C[15:0]=5.
- Priority/counter: estado with cargar+sumar+cont_inc -> C=0 (cargar wins), cont increments. Sixteen cont_inc pulses -> contNOquince=0 at cont=15, then 1 again at wrap to 0. cont_clr+cont_inc -> cont=0.
- Async reset: assert reset=0 mid-multiply, between clock edges -> all registers 0 without waiting for an edge, listo=0, AEScero=1, CNOcero=0. Release reset and run a new cargar -> normal operation.
- Shift edges: C=0x10001, A=0x8001 with desp_der -> C=0x08000, A=0xC000. Same start with desp_izq -> C=0x00003, A=0x0002. Check A0EScero and neg_reg_C_MSB after each.
